// File: rtl/sync_updown_counter.sv
// sync_updown_counter: parametrised synchronous up/down counter with a
// clock-enable prescaler, synchronous clear/load, wrap or saturate modes,
// a combinational terminal-count flag and registered step/overflow pulses.
module sync_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (2**WIDTH) - 1,
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             step
);

  // Prescaler is at least one bit wide even when PRESCALE is 1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_Q  = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PS_ZERO = PW'(0);
  localparam logic [PW-1:0]    PS_ONE  = PW'(1);

  logic [WIDTH-1:0] q_r;
  logic [PW-1:0]    ps_r;
  logic             ovf_r;
  logic             step_r;

  logic [WIDTH-1:0] q_nxt_s;
  logic [PW-1:0]    ps_nxt_s;
  logic             ovf_nxt_s;
  logic             step_nxt_s;
  logic             step_now_s;

  // Loaded values above the modulus are pinned to MAX_VAL so q never leaves range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if (v > MAX_Q) begin
      return MAX_Q;
    end else begin
      return v;
    end
  endfunction

  assign step_now_s = en && (ps_r == PS_LAST);

  // Next-state: clr > load > count step > prescale advance > hold.
  always_comb begin
    q_nxt_s    = q_r;
    ps_nxt_s   = ps_r;
    ovf_nxt_s  = 1'b0;
    step_nxt_s = 1'b0;
    if (clr) begin
      q_nxt_s  = ZERO_Q;
      ps_nxt_s = PS_ZERO;
    end else if (load) begin
      q_nxt_s  = clamp_load(load_val);
      ps_nxt_s = PS_ZERO;
    end else if (step_now_s) begin
      ps_nxt_s   = PS_ZERO;
      step_nxt_s = 1'b1;
      if (up_dn) begin
        if (q_r == MAX_Q) begin
          ovf_nxt_s = 1'b1;
          q_nxt_s   = SATURATE ? q_r : ZERO_Q;
        end else begin
          q_nxt_s = q_r + ONE_Q;
        end
      end else begin
        if (q_r == ZERO_Q) begin
          ovf_nxt_s = 1'b1;
          q_nxt_s   = SATURATE ? q_r : MAX_Q;
        end else begin
          q_nxt_s = q_r - ONE_Q;
        end
      end
    end else if (en) begin
      ps_nxt_s = ps_r + PS_ONE;
    end else begin
      ps_nxt_s = ps_r;
    end
  end

  // State and output pulse registers; async reset discards any partial prescale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r    <= ZERO_Q;
      ps_r   <= PS_ZERO;
      ovf_r  <= 1'b0;
      step_r <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      ps_r   <= ps_nxt_s;
      ovf_r  <= ovf_nxt_s;
      step_r <= step_nxt_s;
    end
  end

  assign q    = q_r;
  assign ovf  = ovf_r;
  assign step = step_r;
  assign tc   = up_dn ? (q_r == MAX_Q) : (q_r == ZERO_Q);

endmodule
